// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that serialises client read/write commands
// onto a single-port memory interface and routes completion, data and timeout back.
module mem_arbiter #(
  parameter int WA   = 32,
  parameter int WD   = 32,
  parameter int TOUT = 255
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          R0_REQ,
  input  logic          R0_WE,
  input  logic [WA-1:0] R0_A,
  input  logic [WD-1:0] R0_D,
  input  logic          R1_REQ,
  input  logic          R1_WE,
  input  logic [WA-1:0] R1_A,
  input  logic [WD-1:0] R1_D,
  output logic          R0_ACK,
  output logic          R0_DONE,
  output logic          R0_ERR,
  output logic [WD-1:0] R0_Q,
  output logic          R1_ACK,
  output logic          R1_DONE,
  output logic          R1_ERR,
  output logic [WD-1:0] R1_Q,
  output logic [WA-1:0] MEM_A,
  output logic          MEM_RE,
  output logic          MEM_WE,
  output logic [WD-1:0] MEM_D,
  input  logic [WD-1:0] MEM_Q,
  input  logic          MEM_BUSY,
  input  logic          MEM_DONE
);

  localparam int            CW       = $clog2(TOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WA-1:0] a_d;
  logic [WD-1:0] d_d, q0_d, q1_d;
  logic [1:0]    ack_d, done_d, err_d;
  logic          re_d, wr_d;
  logic          win;

  // On a tie the requester that did not complete last wins; 1 selects requester 1.
  assign win = (R0_REQ && R1_REQ) ? ~last_q : R1_REQ;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    a_d     = MEM_A;
    d_d     = MEM_D;
    q0_d    = R0_Q;
    q1_d    = R1_Q;
    ack_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = 2'b00;
    re_d    = 1'b0;
    wr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (R0_REQ || R1_REQ) begin
          owner_d    = win;
          we_d       = win ? R1_WE : R0_WE;
          a_d        = win ? R1_A  : R0_A;
          d_d        = win ? R1_D  : R0_D;
          ack_d[win] = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!MEM_BUSY) begin
          re_d    = ~we_q;
          wr_d    = we_q;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A completion in the same cycle as the timeout limit is a normal completion.
        if (MEM_DONE) begin
          done_d[owner_q] = 1'b1;
          if (!we_q) begin
            if (owner_q) q1_d = MEM_Q;
            else         q0_d = MEM_Q;
          end
          last_d  = owner_q;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          last_d          = owner_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      MEM_A   <= '0;
      MEM_D   <= '0;
      MEM_RE  <= 1'b0;
      MEM_WE  <= 1'b0;
      R0_ACK  <= 1'b0;
      R1_ACK  <= 1'b0;
      R0_DONE <= 1'b0;
      R1_DONE <= 1'b0;
      R0_ERR  <= 1'b0;
      R1_ERR  <= 1'b0;
      R0_Q    <= '0;
      R1_Q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      MEM_A   <= a_d;
      MEM_D   <= d_d;
      MEM_RE  <= re_d;
      MEM_WE  <= wr_d;
      R0_ACK  <= ack_d[0];
      R1_ACK  <= ack_d[1];
      R0_DONE <= done_d[0];
      R1_DONE <= done_d[1];
      R0_ERR  <= err_d[0];
      R1_ERR  <= err_d[1];
      R0_Q    <= q0_d;
      R1_Q    <= q1_d;
    end
  end

endmodule
